// File: rtl/cpu_cu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_cu_pkg
// Shared definitions for the control unit:
//   - state_e        : FSM state encoding
//   - CLS_*          : instruction class codes (ir[15:13])
//   - BR_*           : branch condition codes (ir[12:9] of a BR instruction)
//   - ALU_PASS_S/R   : ALU operations used by the control unit
//   - ctrl_t         : bundle of every control output that is registered
//   - is_exec()      : true for the single-cycle EXEC states
// -----------------------------------------------------------------------------
package cpu_cu_pkg;

    typedef enum logic [3:0] {
        RESET     = 4'd0,
        FETCH     = 4'd1,
        DECODE    = 4'd2,
        ALU       = 4'd3,
        LD        = 4'd4,
        ST        = 4'd5,
        BR        = 4'd6,
        JMP       = 4'd7,
        HALT      = 4'd8,
        STEP_WAIT = 4'd9
    } state_e;

    localparam logic [2:0] CLS_ALU  = 3'b000;
    localparam logic [2:0] CLS_LD   = 3'b001;
    localparam logic [2:0] CLS_ST   = 3'b010;
    localparam logic [2:0] CLS_BR   = 3'b011;
    localparam logic [2:0] CLS_JMP  = 3'b100;
    localparam logic [2:0] CLS_ILL5 = 3'b101;
    localparam logic [2:0] CLS_ILL6 = 3'b110;
    localparam logic [2:0] CLS_HLT  = 3'b111;

    localparam logic [3:0] BR_BRA = 4'd0;
    localparam logic [3:0] BR_BEQ = 4'd1;
    localparam logic [3:0] BR_BNE = 4'd2;
    localparam logic [3:0] BR_BC  = 4'd3;
    localparam logic [3:0] BR_BNC = 4'd4;
    localparam logic [3:0] BR_BN  = 4'd5;
    localparam logic [3:0] BR_BP  = 4'd6;

    localparam logic [3:0] ALU_PASS_S = 4'h0;
    localparam logic [3:0] ALU_PASS_R = 4'h1;

    typedef struct packed {
        logic       w_en;
        logic       s_sel;
        logic       adr_sel;
        logic       pc_ld;
        logic       pc_inc;
        logic       pc_sel;
        logic       ir_ld;
        logic [2:0] w_adr;
        logic [2:0] r_adr;
        logic [2:0] s_adr;
        logic [3:0] alu_op;
        logic       mr_en;
        logic       mw_en;
        logic       halted;
    } ctrl_t;

    function automatic logic is_exec(input state_e s);
        case (s)
            ALU, LD, ST, BR, JMP: return 1'b1;
            default:              return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/cpu_cu_brcond.sv
// -----------------------------------------------------------------------------
// cpu_cu_brcond
// Combinational branch condition evaluator.
//   cond[3:0] : condition code from ir[12:9]
//   C, N, Z   : status flags from the execution unit
//   taken     : 1 when the branch must be taken; codes 7..15 are never taken
// -----------------------------------------------------------------------------
module cpu_cu_brcond
    import cpu_cu_pkg::*;
(
    input  logic [3:0] cond,
    input  logic       C,
    input  logic       N,
    input  logic       Z,
    output logic       taken
);

    // Map the condition code onto the flag test it names.
    always_comb begin
        taken = 1'b0;
        case (cond)
            BR_BRA:  taken = 1'b1;
            BR_BEQ:  taken = Z;
            BR_BNE:  taken = ~Z;
            BR_BC:   taken = C;
            BR_BNC:  taken = ~C;
            BR_BN:   taken = N;
            BR_BP:   taken = ~N & ~Z;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/cpu_cu.sv
// -----------------------------------------------------------------------------
// cpu_cu
// Control unit FSM sequencing the execution unit through FETCH, DECODE and a
// single EXEC state (ALU/LD/ST/BR/JMP), with an absorbing HALT state.
//
// Ports:
//   clk, reset            : rising-edge clock, asynchronous active-high reset
//   step                  : single-step advance (only with CU_SINGLE_STEP_EN)
//   ir_out[15:0]          : instruction register from the execution unit
//   C, N, Z               : status flags from the execution unit
//   w_en, s_sel, adr_sel  : register write / S-operand select / address select
//   pc_ld, pc_inc, pc_sel : PC load / increment / source select
//   ir_ld                 : instruction register load
//   W_Adr, R_Adr, S_Adr   : register file addresses
//   ALU_OP[3:0]           : ALU operation
//   mr_en, mw_en          : memory read / write strobes
//   halted                : FSM is in HALT
//   illegal               : sticky, HALT reached through an undefined class
//   instr_cnt[CNT_W-1:0]  : retired-instruction counter (wraps)
//
// Optional feature macro: CU_SINGLE_STEP_EN
//   When defined, each EXEC state is followed by STEP_WAIT, which leaves to
//   FETCH once per low-to-high use of step.
//
// All control outputs are registered: they are decoded from the state being
// entered, so they line up with the state register and are cleared at once
// by the asynchronous reset (aborting any in-flight write).
// -----------------------------------------------------------------------------
module cpu_cu
    import cpu_cu_pkg::*;
#(
    parameter int CNT_W = 16
)
(
    input  logic             clk,
    input  logic             reset,
`ifdef CU_SINGLE_STEP_EN
    input  logic             step,
`endif
    input  logic [15:0]      ir_out,
    input  logic             C,
    input  logic             N,
    input  logic             Z,
    output logic             w_en,
    output logic             s_sel,
    output logic             adr_sel,
    output logic             pc_ld,
    output logic             pc_inc,
    output logic             pc_sel,
    output logic             ir_ld,
    output logic [2:0]       W_Adr,
    output logic [2:0]       R_Adr,
    output logic [2:0]       S_Adr,
    output logic [3:0]       ALU_OP,
    output logic             mr_en,
    output logic             mw_en,
    output logic             halted,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_cnt
);

    state_e             state_r;
    state_e             next_state_s;
    ctrl_t              ctrl_s;
    ctrl_t              ctrl_r;
    logic               taken_s;
    logic               illegal_set_s;
    logic               illegal_r;
    logic [CNT_W-1:0]   instr_cnt_r;

`ifdef CU_SINGLE_STEP_EN
    logic               armed_r;
    logic               advance_s;

    // A step is honoured only once it has been seen low since the last advance.
    assign advance_s = step & armed_r;
`endif

    cpu_cu_brcond u_brcond (
        .cond  (ir_out[12:9]),
        .C     (C),
        .N     (N),
        .Z     (Z),
        .taken (taken_s)
    );

    // Next-state logic.
    always_comb begin
        next_state_s  = state_r;
        illegal_set_s = 1'b0;
        case (state_r)
            RESET:  next_state_s = FETCH;
            FETCH:  next_state_s = DECODE;
            DECODE: begin
                case (ir_out[15:13])
                    CLS_ALU: next_state_s = ALU;
                    CLS_LD:  next_state_s = LD;
                    CLS_ST:  next_state_s = ST;
                    CLS_BR:  next_state_s = BR;
                    CLS_JMP: next_state_s = JMP;
                    CLS_HLT: next_state_s = HALT;
                    CLS_ILL5, CLS_ILL6: begin
                        next_state_s  = HALT;
                        illegal_set_s = 1'b1;
                    end
                    default: begin
                        next_state_s  = HALT;
                        illegal_set_s = 1'b1;
                    end
                endcase
            end
            ALU, LD, ST, BR, JMP: begin
`ifdef CU_SINGLE_STEP_EN
                next_state_s = STEP_WAIT;
`else
                next_state_s = FETCH;
`endif
            end
            HALT:   next_state_s = HALT;
            STEP_WAIT: begin
`ifdef CU_SINGLE_STEP_EN
                if (advance_s) begin
                    next_state_s = FETCH;
                end else begin
                    next_state_s = STEP_WAIT;
                end
`else
                next_state_s = FETCH;
`endif
            end
            default: next_state_s = RESET;
        endcase
    end

    // Control decode for the state about to be entered.
    always_comb begin
        ctrl_s = '0;
        case (next_state_s)
            FETCH: begin
                ctrl_s.adr_sel = 1'b0;
                ctrl_s.mr_en   = 1'b1;
                ctrl_s.ir_ld   = 1'b1;
                ctrl_s.pc_inc  = 1'b1;
            end
            ALU: begin
                ctrl_s.alu_op = ir_out[12:9];
                ctrl_s.w_en   = 1'b1;
                ctrl_s.s_sel  = 1'b0;
                ctrl_s.w_adr  = ir_out[8:6];
                ctrl_s.r_adr  = ir_out[5:3];
                ctrl_s.s_adr  = ir_out[2:0];
            end
            LD: begin
                ctrl_s.adr_sel = 1'b1;
                ctrl_s.mr_en   = 1'b1;
                ctrl_s.s_sel   = 1'b1;
                ctrl_s.alu_op  = ALU_PASS_S;
                ctrl_s.w_en    = 1'b1;
                ctrl_s.w_adr   = ir_out[8:6];
                ctrl_s.r_adr   = ir_out[5:3];
                ctrl_s.s_adr   = ir_out[2:0];
            end
            ST: begin
                ctrl_s.adr_sel = 1'b1;
                ctrl_s.alu_op  = ALU_PASS_S;
                ctrl_s.mw_en   = 1'b1;
                ctrl_s.w_adr   = ir_out[8:6];
                ctrl_s.r_adr   = ir_out[5:3];
                ctrl_s.s_adr   = ir_out[2:0];
            end
            BR: begin
                ctrl_s.w_adr = ir_out[8:6];
                ctrl_s.r_adr = ir_out[5:3];
                ctrl_s.s_adr = ir_out[2:0];
                // Target is post-increment PC + sext(offset), chosen by pc_sel=0.
                if (taken_s) begin
                    ctrl_s.pc_sel = 1'b0;
                    ctrl_s.pc_ld  = 1'b1;
                end else begin
                    ctrl_s.pc_ld  = 1'b0;
                end
            end
            JMP: begin
                ctrl_s.alu_op = ALU_PASS_R;
                ctrl_s.pc_sel = 1'b1;
                ctrl_s.pc_ld  = 1'b1;
                ctrl_s.w_adr  = ir_out[8:6];
                ctrl_s.r_adr  = ir_out[5:3];
                ctrl_s.s_adr  = ir_out[2:0];
            end
            HALT:    ctrl_s.halted = 1'b1;
            default: ctrl_s = '0;
        endcase
    end

    // State and registered control outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= RESET;
            ctrl_r  <= '0;
        end else begin
            state_r <= next_state_s;
            ctrl_r  <= ctrl_s;
        end
    end

    // Retired-instruction counter and sticky illegal-opcode flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_cnt_r <= {CNT_W{1'b0}};
            illegal_r   <= 1'b0;
        end else begin
            if (is_exec(state_r)) begin
                instr_cnt_r <= instr_cnt_r + CNT_W'(1);
            end else begin
                instr_cnt_r <= instr_cnt_r;
            end
            if (illegal_set_s) begin
                illegal_r <= 1'b1;
            end else begin
                illegal_r <= illegal_r;
            end
        end
    end

`ifdef CU_SINGLE_STEP_EN
    // Re-arm single step once step is seen low; disarm on each advance.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            armed_r <= 1'b0;
        end else if ((state_r == STEP_WAIT) && advance_s) begin
            armed_r <= 1'b0;
        end else if (!step) begin
            armed_r <= 1'b1;
        end else begin
            armed_r <= armed_r;
        end
    end
`endif

    assign w_en      = ctrl_r.w_en;
    assign s_sel     = ctrl_r.s_sel;
    assign adr_sel   = ctrl_r.adr_sel;
    assign pc_ld     = ctrl_r.pc_ld;
    assign pc_inc    = ctrl_r.pc_inc;
    assign pc_sel    = ctrl_r.pc_sel;
    assign ir_ld     = ctrl_r.ir_ld;
    assign W_Adr     = ctrl_r.w_adr;
    assign R_Adr     = ctrl_r.r_adr;
    assign S_Adr     = ctrl_r.s_adr;
    assign ALU_OP    = ctrl_r.alu_op;
    assign mr_en     = ctrl_r.mr_en;
    assign mw_en     = ctrl_r.mw_en;
    assign halted    = ctrl_r.halted;
    assign illegal   = illegal_r;
    assign instr_cnt = instr_cnt_r;

endmodule
